// File: rtl/cmd_seq_mstr_pkg.sv
// Shared definitions for the command sequencer master.
//   state_e   : sequencer FSM states
//   opcodes   : UART command opcodes, upper byte of a 24-bit command
//   ACK / NAK : standard response bytes returned by the UART slave
package cmd_seq_mstr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_SENT = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_CHECK     = 3'd5
  } state_e;

  localparam logic [7:0] DUMP_CH     = 8'h01;
  localparam logic [7:0] CFG_GAIN    = 8'h02;
  localparam logic [7:0] TRIG_LVL    = 8'h03;
  localparam logic [7:0] TRIG_POS    = 8'h04;
  localparam logic [7:0] SET_DEC     = 8'h05;
  localparam logic [7:0] TRIG_CFG    = 8'h06;
  localparam logic [7:0] RD_TRIG_CFG = 8'h07;
  localparam logic [7:0] EEP_WRT     = 8'h08;
  localparam logic [7:0] EEP_RD      = 8'h09;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead FIFO holding queued command entries.
// Ports:
//   clk, rst_n        : clock, async active-low reset (empties the FIFO)
//   push_i, wdata_i   : enqueue; dropped while full, even if pop_i is high
//   pop_i             : dequeue the head entry (ignored while empty)
//   rdata_o           : head entry, valid whenever empty_o is low
//   full_o, empty_o   : occupancy flags
module cmd_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cmd_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cmd_seq_mstr.sv
// Command sequencer master: queues {cmd, expected response, check flag}
// entries, sends each command to a UART master, captures the response and
// scores it against the expected byte.
// Optional feature macro: RESP_TIMEOUT_EN (response timeout of TO_CYC cycles).
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   push, cmd_in, exp_in, chk_in: enqueue an entry; full/empty report FIFO state
//   send_cmd, cmd, cmd_sent     : command handshake with the UART master
//   resp_rdy, resp, clr_resp_rdy: response handshake with the UART master
//   busy, last_resp             : sequencer activity, last captured response
//   pass_cnt, fail_cnt, err,
//   timeout, clr_stat           : saturating scoreboard and its clear
//
// state        | meaning
// ST_IDLE      | waiting for a queued entry
// ST_LOAD      | pop head entry into cmd/exp/chk registers
// ST_SEND      | request transmission (send_cmd pulses next cycle)
// ST_WAIT_SENT | waiting for cmd_sent
// ST_WAIT_RESP | waiting for resp_rdy (or timeout)
// ST_CHECK     | score captured response, return to idle
module cmd_seq_mstr
  import cmd_seq_mstr_pkg::*;
#(
  parameter int CMD_W  = 24,
  parameter int RESP_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  parameter int TO_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [RESP_W-1:0] exp_in,
  input  logic              chk_in,
  output logic              full,
  output logic              empty,
  output logic              send_cmd,
  output logic [CMD_W-1:0]  cmd,
  input  logic              cmd_sent,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              clr_resp_rdy,
  output logic              busy,
  output logic [RESP_W-1:0] last_resp,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err,
  output logic              timeout,
  input  logic              clr_stat
);

  localparam int ENT_W = CMD_W + RESP_W + 1;

  if (TO_CYC < 2) begin : g_bad_to
    $error("cmd_seq_mstr: TO_CYC must be >= 2");
  end

  state_e            state_q, state_d;
  logic [CMD_W-1:0]  cmd_q;
  logic [RESP_W-1:0] exp_q;
  logic              chk_q;
  logic [RESP_W-1:0] last_q;
  logic [CNT_W-1:0]  pass_q, fail_q;
  logic              err_q;
  logic              send_q, send_d;
  logic              clr_q, clr_d;
  logic              capture, pass_inc, fail_inc;
  logic [ENT_W-1:0]  fifo_rdata;
  logic              pop;

  assign pop = (state_q == ST_LOAD);

  cmd_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .wdata_i({cmd_in, exp_in, chk_in}),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (full),
    .empty_o(empty)
  );

`ifdef RESP_TIMEOUT_EN
  localparam int TO_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q;
  logic            to_q;
  logic            to_hit;
  logic            to_expired;

  assign to_expired = (to_cnt_q == TO_W'(TO_CYC - 1));
  assign timeout    = to_q;

  // Held at zero outside WAIT_RESP, so every entry starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       to_cnt_q <= '0;
    else if (state_q != ST_WAIT_RESP) to_cnt_q <= '0;
    else                              to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        to_q <= 1'b0;
    else if (clr_stat) to_q <= 1'b0;
    else if (to_hit)   to_q <= 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    send_d   = 1'b0;
    clr_d    = 1'b0;
    capture  = 1'b0;
    pass_inc = 1'b0;
    fail_inc = 1'b0;
`ifdef RESP_TIMEOUT_EN
    to_hit   = 1'b0;
`endif
    case (state_q)
      ST_IDLE:      if (!empty) state_d = ST_LOAD;
      ST_LOAD:      state_d = ST_SEND;
      ST_SEND: begin
        send_d  = 1'b1;
        state_d = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: if (cmd_sent) state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (resp_rdy) begin
          capture = 1'b1;
          clr_d   = 1'b1;
          state_d = ST_CHECK;
        end
`ifdef RESP_TIMEOUT_EN
        else if (to_expired) begin
          fail_inc = 1'b1;
          to_hit   = 1'b1;
          state_d  = ST_IDLE;
        end
`endif
      end
      ST_CHECK: begin
        if (chk_q) begin
          if (last_q == exp_q) pass_inc = 1'b1;
          else                 fail_inc = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      exp_q   <= '0;
      chk_q   <= 1'b0;
      last_q  <= '0;
      send_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      clr_q   <= clr_d;
      if (pop) {cmd_q, exp_q, chk_q} <= fifo_rdata;
      if (capture) last_q <= resp;
    end
  end

  // Clear has priority over any increment landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= '0;
      fail_q <= '0;
      err_q  <= 1'b0;
    end else if (clr_stat) begin
      pass_q <= '0;
      fail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (pass_inc && pass_q != '1) pass_q <= pass_q + CNT_W'(1);
      if (fail_inc) begin
        err_q <= 1'b1;
        if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
      end
    end
  end

  assign send_cmd     = send_q;
  assign clr_resp_rdy = clr_q;
  assign cmd          = cmd_q;
  assign busy         = (state_q != ST_IDLE);
  assign last_resp    = last_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign err          = err_q;

endmodule

// File: tb/tb_cmd_seq_mstr.sv
// Directed bench for cmd_seq_mstr; acts as the UART master for the DUT.
module tb_cmd_seq_mstr;
  import cmd_seq_mstr_pkg::*;

  localparam int CMD_W  = 24;
  localparam int RESP_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int TO_CYC = 1000;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              push = 1'b0, chk_in = 1'b0;
  logic [CMD_W-1:0]  cmd_in = '0;
  logic [RESP_W-1:0] exp_in = '0, resp = '0;
  logic              cmd_sent = 1'b0, resp_rdy = 1'b0, clr_stat = 1'b0;
  logic              full, empty, send_cmd, clr_resp_rdy, busy, err, timeout;
  logic [CMD_W-1:0]  cmd;
  logic [RESP_W-1:0] last_resp;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt;

  int checks = 0, failures = 0;
  int send_cnt = 0, clr_cnt = 0;

  cmd_seq_mstr #(.CMD_W(CMD_W), .RESP_W(RESP_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
                 .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .cmd_in(cmd_in), .exp_in(exp_in),
    .chk_in(chk_in), .full(full), .empty(empty), .send_cmd(send_cmd), .cmd(cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .clr_resp_rdy(clr_resp_rdy), .busy(busy), .last_resp(last_resp),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .timeout(timeout),
    .clr_stat(clr_stat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send_cmd === 1'b1) send_cnt++;
    if (clr_resp_rdy === 1'b1) clr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_one(input logic [CMD_W-1:0] c, input logic [RESP_W-1:0] e,
                          input logic k);
    push = 1'b1; cmd_in = c; exp_in = e; chk_in = k;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_send(output logic [CMD_W-1:0] c, output bit ok);
    ok = 1'b0; c = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (send_cmd === 1'b1) begin ok = 1'b1; c = cmd; end
    end
  endtask

  // Called in WAIT_SENT; returns on the negedge after the CHECK edge.
  task automatic complete(input logic [RESP_W-1:0] r, input bit clr_at_chk, output bit ok);
    cmd_sent = 1'b1;
    @(negedge clk);
    cmd_sent = 1'b0; resp = r; resp_rdy = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (clr_resp_rdy === 1'b1) ok = 1'b1;
    end
    resp_rdy = 1'b0;
    clr_stat = clr_at_chk & ok;
    @(negedge clk);
    clr_stat = 1'b0;
  endtask

  task automatic serve(input logic [RESP_W-1:0] r, output bit ok);
    logic [CMD_W-1:0] c;
    bit ok1, ok2;
    wait_send(c, ok1);
    ok2 = 1'b0;
    if (ok1) complete(r, 1'b0, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if ({send_cmd, clr_resp_rdy, busy, err, timeout} !== 5'b0) begin
      failures++; $display("FAIL rst_flags got=%b exp=00000", {send_cmd, clr_resp_rdy, busy, err, timeout}); end
    checks++; if ({cmd, last_resp, pass_cnt, fail_cnt} !== '0) begin
      failures++; $display("FAIL rst_values got cmd=%h last=%h pass=%0d fail=%0d exp all 0",
                           cmd, last_resp, pass_cnt, fail_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass_latency();
    bit ok;
    push_one({CFG_GAIN, 16'h0300}, ACK, 1'b1);
    checks++; if ({send_cmd, busy, empty} !== 3'b000) begin
      failures++; $display("FAIL lat_e0 got send/busy/empty=%b exp=000", {send_cmd, busy, empty}); end
    @(negedge clk);
    checks++; if ({send_cmd, busy} !== 2'b01) begin
      failures++; $display("FAIL lat_e1 got send/busy=%b exp=01", {send_cmd, busy}); end
    @(negedge clk);
    checks++; if (send_cmd !== 1'b0) begin failures++; $display("FAIL lat_e2 got send=%b exp=0", send_cmd); end
    @(negedge clk);
    checks++; if (send_cmd !== 1'b1) begin failures++; $display("FAIL lat_e3 got send=%b exp=1", send_cmd); end
    checks++; if (cmd !== 24'h020300) begin failures++; $display("FAIL lat_cmd got=%h exp=020300", cmd); end
    complete(ACK, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL pass_handshake got=%b exp=1", ok); end
    checks++; if ({pass_cnt, fail_cnt, err} !== {3'd1, 3'd0, 1'b0}) begin
      failures++; $display("FAIL pass_counts got pass=%0d fail=%0d err=%b exp 1 0 0", pass_cnt, fail_cnt, err); end
    checks++; if (last_resp !== 8'hA5) begin failures++; $display("FAIL pass_last got=%h exp=a5", last_resp); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pass_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_mismatch();
    bit ok;
    push_one({CFG_GAIN, 16'h07C0}, ACK, 1'b1);
    serve(NAK, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mis_handshake got=%b exp=1", ok); end
    checks++; if ({pass_cnt, fail_cnt, err} !== {3'd1, 3'd1, 1'b1}) begin
      failures++; $display("FAIL mis_counts got pass=%0d fail=%0d err=%b exp 1 1 1", pass_cnt, fail_cnt, err); end
    checks++; if (last_resp !== 8'hEE) begin failures++; $display("FAIL mis_last got=%h exp=ee", last_resp); end
  endtask

  task automatic test_capture_only();
    bit ok;
    push_one({EEP_RD, 16'h0010}, 8'h00, 1'b0);
    serve(8'h5A, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cap_handshake got=%b exp=1", ok); end
    checks++; if ({pass_cnt, fail_cnt} !== {3'd1, 3'd1}) begin
      failures++; $display("FAIL cap_counts got pass=%0d fail=%0d exp 1 1", pass_cnt, fail_cnt); end
    checks++; if (last_resp !== 8'h5A) begin failures++; $display("FAIL cap_last got=%h exp=5a", last_resp); end
  endtask

  task automatic test_stray_resp();
    bit seen = 1'b0;
    resp = 8'h3C; resp_rdy = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (clr_resp_rdy !== 1'b0) seen = 1'b1;
    end
    resp_rdy = 1'b0;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL stray_clr got=%b exp=0", seen); end
    checks++; if ({last_resp, busy} !== {8'h5A, 1'b0}) begin
      failures++; $display("FAIL stray_state got last=%h busy=%b exp 5a 0", last_resp, busy); end
  endtask

  task automatic test_clr_stat();
    logic [CMD_W-1:0] c;
    bit ok;
    push_one({TRIG_LVL, 16'h0040}, ACK, 1'b1);
    wait_send(c, ok);
    if (ok) complete(NAK, 1'b1, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL clr_handshake got=%b exp=1", ok); end
    checks++; if ({pass_cnt, fail_cnt, err} !== 7'b0) begin
      failures++; $display("FAIL clr_coincident got pass=%0d fail=%0d err=%b exp 0 0 0", pass_cnt, fail_cnt, err); end
    checks++; if (last_resp !== 8'hEE) begin failures++; $display("FAIL clr_last got=%h exp=ee", last_resp); end
    push_one({TRIG_LVL, 16'h0041}, ACK, 1'b1);
    serve(ACK, ok);
    checks++; if (pass_cnt !== 3'd1) begin failures++; $display("FAIL clr_recount got pass=%0d exp=1", pass_cnt); end
    clr_stat = 1'b1; @(negedge clk); clr_stat = 1'b0;
    checks++; if ({pass_cnt, fail_cnt, err} !== 7'b0) begin
      failures++; $display("FAIL clr_plain got pass=%0d fail=%0d err=%b exp 0 0 0", pass_cnt, fail_cnt, err); end
  endtask

  task automatic test_back_to_back();
    logic [CMD_W-1:0] q_exp [4];
    logic [CMD_W-1:0] c;
    bit ok;
    int s0, c0;
    q_exp[0] = {DUMP_CH, 16'h0001};
    q_exp[1] = {SET_DEC, 16'h0003};
    q_exp[2] = {TRIG_POS, 16'h0100};
    q_exp[3] = {RD_TRIG_CFG, 16'h0000};
    push_one({TRIG_CFG, 16'h0011}, 8'h00, 1'b0);
    wait_send(c, ok);
    checks++; if (c !== {TRIG_CFG, 16'h0011}) begin
      failures++; $display("FAIL b2b_stall_cmd got=%h exp=%h", c, {TRIG_CFG, 16'h0011}); end
    for (int i = 0; i < 4; i++) push_one(q_exp[i], 8'h00, 1'b0);
    checks++; if ({full, empty} !== 2'b10) begin
      failures++; $display("FAIL b2b_full got full/empty=%b exp=10", {full, empty}); end
    push_one({EEP_RD, 16'hDEAD}, 8'h00, 1'b0);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL b2b_drop_full got=%b exp=1", full); end
    complete(ACK, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_release got=%b exp=1", ok); end
    s0 = send_cnt; c0 = clr_cnt;
    for (int i = 0; i < 4; i++) begin
      wait_send(c, ok);
      checks++; if (c !== q_exp[i]) begin
        failures++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, c, q_exp[i]); end
      if (ok) complete(8'h10 + 8'(i), 1'b0, ok);
    end
    checks++; if ((send_cnt - s0) != 4 || (clr_cnt - c0) != 4) begin
      failures++; $display("FAIL b2b_pulses got send=%0d clr=%0d exp 4 4", send_cnt - s0, clr_cnt - c0); end
    repeat (20) @(negedge clk);
    checks++; if ((send_cnt - s0) != 4 || {empty, busy} !== 2'b10) begin
      failures++; $display("FAIL b2b_drained got send=%0d empty/busy=%b exp 4 10", send_cnt - s0, {empty, busy}); end
    checks++; if (last_resp !== 8'h13) begin failures++; $display("FAIL b2b_last got=%h exp=13", last_resp); end
  endtask

  task automatic test_saturation();
    bit ok, all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_one({EEP_WRT, 16'(i)}, ACK, 1'b1);
      serve(NAK, ok);
      all_ok &= ok;
    end
    checks++; if ({fail_cnt, err, pass_cnt} !== {3'd7, 1'b1, 3'd0}) begin
      failures++; $display("FAIL sat_fail got fail=%0d err=%b pass=%0d exp 7 1 0", fail_cnt, err, pass_cnt); end
    for (int i = 0; i < 8; i++) begin
      push_one({EEP_WRT, 16'(i)}, NAK, 1'b1);
      serve(NAK, ok);
      all_ok &= ok;
    end
    checks++; if ({pass_cnt, fail_cnt} !== {3'd7, 3'd7}) begin
      failures++; $display("FAIL sat_pass got pass=%0d fail=%0d exp 7 7", pass_cnt, fail_cnt); end
    checks++; if (all_ok !== 1'b1) begin failures++; $display("FAIL sat_handshake got=%b exp=1", all_ok); end
    clr_stat = 1'b1; @(negedge clk); clr_stat = 1'b0;
  endtask

  task automatic test_timeout();
    logic [CMD_W-1:0] c;
    bit ok;
    push_one({TRIG_LVL, 16'h0080}, ACK, 1'b1);
    wait_send(c, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL to_send got=%b exp=1", ok); end
    cmd_sent = 1'b1;
    @(negedge clk);
    cmd_sent = 1'b0;
    repeat (TO_CYC - 1) @(negedge clk);
    checks++; if ({timeout, busy} !== 2'b01) begin
      failures++; $display("FAIL to_before got timeout/busy=%b exp=01", {timeout, busy}); end
    @(negedge clk);
`ifdef RESP_TIMEOUT_EN
    checks++; if ({timeout, fail_cnt, err, busy} !== {1'b1, 3'd1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL to_fire got timeout=%b fail=%0d err=%b busy=%b exp 1 1 1 0",
                           timeout, fail_cnt, err, busy); end
`else
    checks++; if ({timeout, fail_cnt, busy} !== {1'b0, 3'd0, 1'b1}) begin
      failures++; $display("FAIL to_nofire got timeout=%b fail=%0d busy=%b exp 0 0 1", timeout, fail_cnt, busy); end
    resp = ACK; resp_rdy = 1'b1; ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (clr_resp_rdy === 1'b1) ok = 1'b1;
    end
    resp_rdy = 1'b0;
    @(negedge clk);
    checks++; if ({ok, pass_cnt, busy} !== {1'b1, 3'd1, 1'b0}) begin
      failures++; $display("FAIL to_late_resp got ok=%b pass=%0d busy=%b exp 1 1 0", ok, pass_cnt, busy); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [CMD_W-1:0] c;
    bit ok;
    int s0;
    push_one({DUMP_CH, 16'h0002}, ACK, 1'b1);
    wait_send(c, ok);
    cmd_sent = 1'b1; @(negedge clk); cmd_sent = 1'b0;
    push_one({DUMP_CH, 16'h0003}, ACK, 1'b1);
    push_one({DUMP_CH, 16'h0004}, ACK, 1'b1);
    checks++; if ({ok, busy, empty} !== 3'b110) begin
      failures++; $display("FAIL mid_setup got ok/busy/empty=%b exp=110", {ok, busy, empty}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({full, empty, send_cmd, clr_resp_rdy, busy, err, timeout} !== 7'b0100000) begin
      failures++; $display("FAIL mid_rst_flags got=%b exp=0100000",
                           {full, empty, send_cmd, clr_resp_rdy, busy, err, timeout}); end
    checks++; if ({cmd, last_resp, pass_cnt, fail_cnt} !== '0) begin
      failures++; $display("FAIL mid_rst_values got cmd=%h last=%h pass=%0d fail=%0d exp all 0",
                           cmd, last_resp, pass_cnt, fail_cnt); end
    @(negedge clk);
    s0 = send_cnt;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (send_cnt != s0 || {busy, empty} !== 2'b01) begin
      failures++; $display("FAIL mid_after got sends=%0d busy/empty=%b exp 0 01", send_cnt - s0, {busy, empty}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pass_latency();
    test_mismatch();
    test_capture_only();
    test_stray_resp();
    test_clr_stat();
    test_back_to_back();
    test_saturation();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_seq_mstr.md
CMD_SEQ_MSTR -- requirements
Module: cmd_seq_mstr

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  CMD_W 24 command width, {opcode, 16-bit payload}
  RESP_W 8 response width
  DEPTH 4 command FIFO entries, power of 2, >=2
  CNT_W 8 pass/fail counter width
  TO_CYC 1000000 response timeout in clk cycles
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk in 1 system clock
  rst_n in 1 reset, asynchronous, active-low
  push in 1 enqueue {cmd_in, exp_in, chk_in}
  cmd_in in CMD_W command to send
  exp_in in RESP_W expected response
  chk_in in 1 1 = compare response, 0 = capture only
  full out 1 FIFO full
  empty out 1 FIFO empty
  send_cmd out 1 one-cycle pulse to UART master
  cmd out CMD_W command to UART master
  cmd_sent in 1 UART master finished transmitting
  resp_rdy in 1 UART master holds a response
  resp in RESP_W response byte
  clr_resp_rdy out 1 one-cycle pulse acknowledging resp
  busy out 1 state != IDLE
  last_resp out RESP_W most recent captured response
  pass_cnt out CNT_W compared responses that matched
  fail_cnt out CNT_W mismatches plus timeouts
  err out 1 sticky failure flag
  timeout out 1 sticky timeout flag
  clr_stat in 1 clear counters, err, timeout

Function
REQ-003 FIFO: push while full is ignored, with no state change; simultaneous push and pop while full is also ignored.
REQ-004 FSM states are IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP and CHECK.
REQ-005 IDLE->LOAD when !empty; LOAD pops the head entry into cmd/exp/chk registers; LOAD->SEND.
REQ-006 SEND asserts send_cmd for exactly one cycle, then goes to WAIT_SENT; push into empty FIFO while IDLE -> send_cmd high 3 cycles after the push edge.
REQ-007 cmd is held stable from LOAD until the next LOAD.
REQ-008 WAIT_SENT->WAIT_RESP on cmd_sent.
REQ-009 In WAIT_RESP, resp_rdy captures resp into last_resp, pulses clr_resp_rdy for one cycle and moves to CHECK.
REQ-010 CHECK: if chk=1 and resp==exp, pass_cnt+1; if chk=1 and resp!=exp, fail_cnt+1 and err=1; if chk=0, no counter change; then IDLE.
REQ-011 Counters saturate at all-ones and never wrap.
REQ-012 clr_stat zeroes pass_cnt, fail_cnt, err and timeout; when coincident with an increment, clear wins; FIFO and FSM are unaffected.
REQ-013 resp_rdy outside WAIT_RESP is ignored and clr_resp_rdy stays 0.

Reset
REQ-014 rst_n low asynchronously forces: IDLE, FIFO empty (full=0, empty=1), send_cmd=0, clr_resp_rdy=0, busy=0, cmd=0, last_resp=0, counters=0, err=0, timeout=0.
REQ-015 Reset mid-transaction discards the in-flight command and all queued entries.

Configuration
REQ-016 Macro RESP_TIMEOUT_EN defined: a counter clears on entry to WAIT_RESP; when it reaches TO_CYC-1 with no resp_rdy, fail_cnt+1, err=1, timeout=1, and the FSM goes to IDLE.
REQ-017 RESP_TIMEOUT_EN undefined: WAIT_RESP waits indefinitely, timeout is tied to 0, and no timeout counter is synthesized.

Structure
REQ-018 Shared package holds the state enum, the UART opcode constants (DUMP_CH, CFG_GAIN, TRIG_LVL, TRIG_POS, SET_DEC, TRIG_CFG, RD_TRIG_CFG, EEP_WRT, EEP_RD) and the ACK=8'hA5 / NAK=8'hEE constants.
REQ-019 The FIFO is one sub-module, cmd_fifo, parametrised by width and DEPTH.

Verification
REQ-020 Push 24'h020300, exp 8'hA5, chk 1; model returns 8'hA5 -> pass_cnt=1, err=0, last_resp=8'hA5.
REQ-021 Push 24'h0207C0, exp 8'hA5; model returns 8'hEE -> fail_cnt=1, err=1.
REQ-022 With the sequencer stalled in WAIT_SENT, 4 pushes -> full=1; a 5th push is dropped; after release, exactly 4 send_cmd pulses and 4 clr_resp_rdy pulses occur in order.
REQ-023 RESP_TIMEOUT_EN, TO_CYC=1000, no resp_rdy -> timeout=1 and fail_cnt=1 exactly 1000 cycles after entry to WAIT_RESP, then IDLE.
REQ-024 rst_n low during WAIT_RESP with 2 entries queued -> all REQ-014 values immediately; no send_cmd after release.
REQ-025 clr_stat coincident with CHECK mismatch -> fail_cnt=0, err=0.
